// File: rtl/multiplicador_secuencial_pkg.sv
// Shared definitions for sequential arithmetic blocks: FSM state encoding
// and iteration-counter sizing.
package multiplicador_secuencial_pkg;

  localparam int unsigned SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Counter must represent 0..n inclusive.
  function automatic int unsigned seq_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplicador_secuencial_sumador.sv
// N-bit ripple adder with carry-in, carry-out and signed overflow flag.
module sumador #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V
);

  localparam int unsigned FW = N + 1;

  logic [N:0] full_sum;

  always_comb begin
    full_sum = FW'(A) + FW'(B) + FW'(Cin);
  end

  assign S    = full_sum[N-1:0];
  assign Cout = full_sum[N];
  // Two same-sign operands producing an opposite-sign result.
  assign V    = (A[N-1] == B[N-1]) && (S[N-1] != A[N-1]);

endmodule

// File: rtl/multiplicador_secuencial.sv
// Shift-and-add unsigned multiplier: one partial product per cycle,
// N cycles per product, one-cycle done pulse with the registered result.
module multiplicador_secuencial
  import multiplicador_secuencial_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CNT_W = seq_cnt_width(N);
  localparam int unsigned PW    = 2 * N;

  seq_state_e       state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             carry;

  sumador #(.N(N)) u_sumador (
    .A   (acc_q),
    .B   (addend),
    .Cin (1'b0),
    .S   (sum),
    .Cout(carry),
    .V   ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    addend  = mq_q[0] ? mcand_q : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = A;
          mq_d    = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // {acc,mq} shifts right as one register; the LSB of each sum moves into mq.
        acc_d = {carry, sum[N-1:1]};
        mq_d  = {sum[0], mq_q[N-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          p_d     = {carry, sum[N-1:1], sum[0], mq_q[N-1:1]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench for the sequential multiplier at N=8 and N=4.
module tb_multiplicador_secuencial;

  typedef struct {
    int prod;
    int edge_n;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic        busy8, done8, busy4, done4;

  int   nchk;
  int   nfail;
  int   cyc;
  int   held8, held4;
  exp_t sb8[$];
  exp_t sb4[$];

  multiplicador_secuencial #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .P(p8), .busy(busy8), .done(done8)
  );

  multiplicador_secuencial #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .P(p4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    nchk++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge rst_n) begin
    held8 = 0;
    held4 = 0;
  end

  // Monitors: pop an expected product whenever done is seen, else P must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done8) begin
        if (sb8.size() == 0) begin
          chk("done8_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb8.pop_front();
          chk("p8_result", longint'(p8), longint'(e.prod));
          chk("done8_latency", cyc, e.edge_n);
          held8 = e.prod;
        end
      end else begin
        chk("p8_hold", longint'(p8), longint'(held8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done4) begin
        if (sb4.size() == 0) begin
          chk("done4_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb4.pop_front();
          chk("p4_result", longint'(p4), longint'(e.prod));
          chk("done4_latency", cyc, e.edge_n);
          held4 = e.prod;
        end
      end else begin
        chk("p4_hold", longint'(p4), longint'(held4));
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int bc;
    bc = 0;
    a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back('{int'(a) * int'(b), cyc + 1 + 8});
    @(posedge clk); #1;
    if (!hold) start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy8) bc++;
      @(posedge clk); #1;
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    @(negedge clk);
    chk("busy8_cycles", bc, 8);
    chk("busy8_in_done", longint'(busy8), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    a4 = a; b4 = b; start4 = 1'b1;
    sb4.push_back('{int'(a) * int'(b), cyc + 1 + 4});
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy4_in_done", longint'(busy4), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts A=100,B=3, resets after four CALC edges, then releases reset at a negedge.
  task automatic abort8();
    a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_p8", longint'(p8), 0);
    chk("rst_busy8", longint'(busy8), 0);
    chk("rst_done8", longint'(done8), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nfail = 0; cyc = 0; held8 = 0; held4 = 0;
    rst_n = 1'b0;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #12;
    chk("reset_p8", longint'(p8), 0);
    chk("reset_busy8", longint'(busy8), 0);
    chk("reset_done8", longint'(done8), 0);
    chk("reset_p4", longint'(p4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'd13, 8'd11, 1'b0);
    op8(8'd255, 8'd255, 1'b0);
    op8(8'd0, 8'd200, 1'b0);
    op8(8'd200, 8'd1, 1'b0);
    op8(8'd77, 8'd91, 1'b1);
    op8(8'd5, 8'd250, 1'b0);
    abort8();
    op8(8'd100, 8'd3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), (i != 39) && ($urandom_range(0, 1) == 1));
    end
    start8 = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b));
      end
    end

    repeat (20) @(negedge clk);
    chk("sb8_drained", sb8.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
